// File: rtl/camera_ctrl_pkg.sv
// camera_ctrl_pkg: shared state encoding and exposure defaults for the camera controller.
package camera_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_EXPOSE, ST_READOUT} state_e;
  localparam int READOUT_LEN = 8;
  localparam int EXP_MIN_DEF = 2;
  localparam int EXP_MAX_DEF = 30;
  localparam int EXP_DEFAULT_DEF = 16;
endpackage

// File: rtl/exposure_control_if.sv
// exposure_control_if: button/timer inputs and pixel/timer outputs of the exposure controller.
interface exposure_control_if #(parameter int EXP_W = 5);
  logic Init, Exp_increase, Exp_decrease, Ovf5;
  logic Start, Erase, Expose, NRE_1, NRE_2, ADC, Err;
  logic [EXP_W-1:0] Initial;
  modport master (
    output Init, Exp_increase, Exp_decrease, Ovf5,
    input Start, Initial, Erase, Expose, NRE_1, NRE_2, ADC, Err
  );
  modport slave (
    input Init, Exp_increase, Exp_decrease, Ovf5,
    output Start, Initial, Erase, Expose, NRE_1, NRE_2, ADC, Err
  );
endinterface

// File: rtl/exposure_control_adjust.sv
// exposure_adjust: saturating up/down exposure-time register, updated only while enabled.
module exposure_adjust import camera_ctrl_pkg::*; #(
  parameter int W = 5,
  parameter logic [W-1:0] MIN = W'(EXP_MIN_DEF),
  parameter logic [W-1:0] MAX = W'(EXP_MAX_DEF),
  parameter logic [W-1:0] DEF = W'(EXP_DEFAULT_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_inc,
  input  logic i_dec,
  output logic [W-1:0] o_val
);
  logic [W-1:0] r_val;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_val <= DEF;
    else if (i_en && i_inc && !i_dec && r_val < MAX) r_val <= r_val + 1'b1;
    else if (i_en && i_dec && !i_inc && r_val > MIN) r_val <= r_val - 1'b1;
  assign o_val = r_val;
endmodule

// File: rtl/exposure_control.sv
// exposure_control: Moore FSM sequencing erase, timed exposure and two-row readout.
// Define EXPOSURE_CTRL_WATCHDOG_EN to abort exposures whose Ovf5 never arrives and flag Err.
module exposure_control import camera_ctrl_pkg::*; #(
  parameter int EXP_W = 5,
  parameter int EXP_MIN = EXP_MIN_DEF,
  parameter int EXP_MAX = EXP_MAX_DEF,
  parameter int EXP_DEFAULT = EXP_DEFAULT_DEF,
  parameter int WD_MARGIN = 4
) (
  input logic Clk,
  input logic Reset,
  exposure_control_if.slave bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] START = ST_START;
  localparam logic [1:0] EXPOSE = ST_EXPOSE;
  localparam logic [1:0] READOUT = ST_READOUT;
  localparam logic [2:0] LAST_STEP = 3'(READOUT_LEN - 1);
  localparam logic [EXP_W+1:0] WD_OFF = (EXP_W + 2)'(WD_MARGIN - 1);
`ifdef EXPOSURE_CTRL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  logic [1:0] r_state, w_nstate;
  logic [2:0] r_step, w_nstep;
  logic [EXP_W+1:0] r_wd;
  logic [EXP_W-1:0] w_initial;
  logic w_wd_exp;
  logic r_start, r_erase, r_expose, r_nre1, r_nre2, r_adc, r_err;
  exposure_adjust #(
    .W(EXP_W), .MIN(EXP_W'(EXP_MIN)), .MAX(EXP_W'(EXP_MAX)), .DEF(EXP_W'(EXP_DEFAULT))
  ) u_adjust (
    .clk(Clk), .rst(Reset), .i_en(r_state == IDLE && !bus.Init),
    .i_inc(bus.Exp_increase), .i_dec(bus.Exp_decrease), .o_val(w_initial)
  );
  // r_wd counts completed EXPOSE cycles; expiry lands on cycle Initial+WD_MARGIN
  assign w_wd_exp = WD_EN && r_state == EXPOSE && r_wd == {2'b00, w_initial} + WD_OFF;
  always_comb begin
    w_nstate = r_state;
    w_nstep = '0;
    case (r_state)
      IDLE: w_nstate = bus.Init ? START : IDLE;
      START: w_nstate = EXPOSE;
      EXPOSE: w_nstate = bus.Ovf5 ? READOUT : (w_wd_exp ? IDLE : EXPOSE);
      default: begin
        w_nstate = (r_step == LAST_STEP) ? IDLE : READOUT;
        w_nstep = r_step + 1'b1;
      end
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_state <= IDLE;
      r_step <= '0;
      r_wd <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_step <= w_nstep;
      r_wd <= (r_state == EXPOSE) ? r_wd + 1'b1 : '0;
      r_err <= (r_state == IDLE && bus.Init) ? 1'b0 : (r_err || (w_wd_exp && !bus.Ovf5));
    end
  // outputs are decoded from the next state so they line up with the state they describe
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_start <= 1'b0;
      r_erase <= 1'b1;
      r_expose <= 1'b0;
      r_nre1 <= 1'b1;
      r_nre2 <= 1'b1;
      r_adc <= 1'b0;
    end else begin
      r_start <= w_nstate == START;
      r_erase <= w_nstate == IDLE;
      r_expose <= w_nstate == START || w_nstate == EXPOSE;
      r_nre1 <= !(w_nstate == READOUT && w_nstep < 3'd3);
      r_nre2 <= !(w_nstate == READOUT && w_nstep[2] && w_nstep != 3'd7);
      r_adc <= w_nstate == READOUT && w_nstep[1:0] == 2'd1;
    end
  assign bus.Start = r_start;
  assign bus.Erase = r_erase;
  assign bus.Expose = r_expose;
  assign bus.NRE_1 = r_nre1;
  assign bus.NRE_2 = r_nre2;
  assign bus.ADC = r_adc;
  assign bus.Err = r_err;
  assign bus.Initial = w_initial;
endmodule

// File: tb/tb_exposure_control.sv
// tb_exposure_control: directed plus random stimulus checked against a cycle model of the controller.
module tb_exposure_control;
`ifdef EXPOSURE_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  exposure_control_if #(.EXP_W(5)) bus();
  exposure_control dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  // model: phase 0 idle, 1 start, 2 exposing, 3 readout step m_k
  int m_ph, m_k, m_wd, m_exp;
  bit m_err;
  function automatic int sat(int v);
    return v < 2 ? 2 : (v > 30 ? 30 : v);
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_ph <= 0; m_k <= 0; m_wd <= 0; m_exp <= 16; m_err <= 1'b0;
    end else
      case (m_ph)
        0: if (bus.Init) begin m_ph <= 1; m_err <= 1'b0; end
           else if (bus.Exp_increase != bus.Exp_decrease) m_exp <= sat(m_exp + (bus.Exp_increase ? 1 : -1));
        1: begin m_ph <= 2; m_wd <= 0; end
        2: if (bus.Ovf5) begin m_ph <= 3; m_k <= 0; end
           else if (WD && m_wd + 1 >= m_exp + 4) begin m_ph <= 0; m_err <= 1'b1; end
           else m_wd <= m_wd + 1;
        default: if (m_k == 7) m_ph <= 0; else m_k <= m_k + 1;
      endcase
  function automatic logic [11:0] model_out();
    logic ro;
    ro = (m_ph == 3);
    return {m_ph == 1, m_ph == 0, m_ph == 1 || m_ph == 2, !(ro && m_k <= 2),
            !(ro && m_k >= 4 && m_k <= 6), ro && (m_k == 1 || m_k == 5), m_err, 5'(m_exp)};
  endfunction
  wire [11:0] dut_out = {bus.Start, bus.Erase, bus.Expose, bus.NRE_1, bus.NRE_2, bus.ADC, bus.Err, bus.Initial};
  always @(negedge clk)
    if (!rst) begin
      n_cmp++;
      if (dut_out !== model_out()) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t got %b required %b (Start,Erase,Expose,NRE_1,NRE_2,ADC,Err,Initial[4:0])",
                 $time, dut_out, model_out());
      end
    end
  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  initial begin
    int n_start, n_exp, n_adc, n_nre, first_idle;
    {bus.Init, bus.Exp_increase, bus.Exp_decrease, bus.Ovf5} = 4'b0;
    @(negedge clk);
    chk("rst_initial", int'(bus.Initial), 16);
    chk("rst_erase_nre", int'({bus.Erase, bus.NRE_1, bus.NRE_2}), 7);
    chk("rst_others", int'({bus.Start, bus.Expose, bus.ADC, bus.Err}), 0);
    #1 rst = 1'b0;
    bus.Exp_increase = 1'b1;
    repeat (20) @(negedge clk);
    bus.Exp_increase = 1'b0;
    chk("sat_max", int'(bus.Initial), 30);
    bus.Exp_decrease = 1'b1;
    repeat (40) @(negedge clk);
    chk("sat_min", int'(bus.Initial), 2);
    bus.Exp_increase = 1'b1;
    repeat (5) @(negedge clk);
    chk("both_buttons", int'(bus.Initial), 2);
    bus.Exp_decrease = 1'b0;
    repeat (3) @(negedge clk);
    bus.Exp_increase = 1'b0;
    chk("inc_three", int'(bus.Initial), 5);
    // single exposure, Ovf5 sampled 10 cycles after the Start cycle
    n_start = 0; n_exp = 0; n_adc = 0; first_idle = 0;
    bus.Init = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      bus.Init = 1'b0;
      n_start += int'(bus.Start);
      n_exp += int'(bus.Expose);
      n_adc += int'(bus.ADC);
      if (i == 13 || i == 17) chk("adc_position", int'(bus.ADC), 1);
      if (first_idle == 0 && bus.Erase) first_idle = i;
      bus.Ovf5 = (i == 11);
    end
    chk("start_pulses", n_start, 1);
    chk("expose_cycles", n_exp, 11);
    chk("adc_pulses", n_adc, 2);
    chk("idle_cycle", first_idle, 20);
    // buttons held outside IDLE and a stale Ovf5 in START
    n_start = 0;
    {bus.Init, bus.Exp_increase} = 2'b11;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      n_start += int'(bus.Start);
      if (i == 2) chk("stale_ovf_ignored", int'(bus.Expose), 1);
      bus.Ovf5 = (i == 1 || i == 6);
      if (i == 14) {bus.Init, bus.Exp_increase} = 2'b00;
    end
    chk("no_restart", n_start, 1);
    chk("no_adjust", int'(bus.Initial), 5);
    // asynchronous reset during readout step 5
    bus.Init = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      bus.Init = 1'b0;
      bus.Ovf5 = (i == 3);
    end
    chk("step5_adc", int'(bus.ADC), 1);
    chk("step5_nre2", int'(bus.NRE_2), 0);
    #1 rst = 1'b1;
    #1;
    chk("async_adc", int'(bus.ADC), 0);
    chk("async_nre2", int'(bus.NRE_2), 1);
    chk("async_erase", int'(bus.Erase), 1);
    chk("async_initial", int'(bus.Initial), 16);
    @(negedge clk);
    #1 rst = 1'b0;
    bus.Exp_decrease = 1'b1;
    repeat (11) @(negedge clk);
    bus.Exp_decrease = 1'b0;
    chk("dec_to_5", int'(bus.Initial), 5);
    n_nre = 0;
    bus.Init = 1'b1;
`ifdef EXPOSURE_CTRL_WATCHDOG_EN
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      bus.Init = 1'b0;
      n_nre += int'(!bus.NRE_1 || !bus.NRE_2 || bus.ADC);
      if (i == 10) chk("wd_not_yet", int'({bus.Err, bus.Expose}), 1);
      if (i == 11) chk("wd_fired", int'({bus.Err, bus.Erase}), 3);
    end
    chk("wd_no_readout", n_nre, 0);
    bus.Init = 1'b1;
    @(negedge clk);
    bus.Init = 1'b0;
    chk("wd_err_cleared", int'(bus.Err), 0);
`else
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bus.Init = 1'b0;
      n_nre += int'(!bus.NRE_1 || !bus.NRE_2 || bus.ADC);
    end
    chk("waits_for_ovf", int'({bus.Err, bus.Expose}), 1);
    chk("no_readout_yet", n_nre, 0);
`endif
    @(negedge clk);
    bus.Ovf5 = 1'b1;
    @(negedge clk);
    bus.Ovf5 = 1'b0;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.Init = ($urandom_range(15) == 0);
      bus.Exp_increase = ($urandom_range(3) == 0);
      bus.Exp_decrease = ($urandom_range(3) == 0);
      bus.Ovf5 = ($urandom_range(7) == 0);
      if ($urandom_range(499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
